out_scheduler: RTL and testbench
================================

# out_scheduler

Round-robin scheduler sharing one serial output stream between several layer-result requesters. Each requester presents a full parallel layer result (NUM_NEURON words) with a valid flag. The scheduler grants one requester, captures its bus, and emits the words LSB-first, one per accepted beat, under a valid/ready handshake. It sits between the parallel layer outputs and the single downstream word channel, replacing per-layer serializers.

## Interface
- NUM_REQ, 4, number of requesters; must be ≥ 2.
- NUM_NEURON, 30, words per layer result; must be ≥ 1.
- Word width is the global `dataWidth define.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  bit i high = requester i has a result pending.
- req_data  input  NUM_REQ*NUM_NEURON*`dataWidth  requester i occupies slice i; word 0 in that slice's LSBs.
- req_ack  output  NUM_REQ  one-cycle pulse on bit i when requester i's data is captured.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts the word this cycle.
- out_data  output  `dataWidth  current word.
- out_src  output  $clog2(NUM_REQ)  index of the granted requester.
- out_last  output  1  high with the final word (index NUM_NEURON-1).
- busy  output  1  high while in SEND.

## Operation
- States: IDLE, SEND.
- IDLE:
  - out_valid=0, out_last=0, busy=0.
  - If any req_valid bit is set, grant the first set bit at or after the round-robin pointer, wrapping modulo NUM_REQ.
  - On grant: capture that requester's slice into the hold register; load word 0 into out_data; set out_src; pulse req_ack[grant]; set out_valid=1, busy=1; counter=0; go to SEND.
- SEND:
  - On out_valid && out_ready: if counter == NUM_NEURON-1, clear out_valid/out_last, set pointer = (grant+1) mod NUM_REQ, go to IDLE. Otherwise increment the counter and present the next word (hold register shifted right by `dataWidth).
  - out_last = (counter == NUM_NEURON-1) && out_valid.
  - When out_ready=0, out_data, out_last and out_src hold.
- Handshake with requesters:
  - A requester holds req_valid and req_data stable until it sees its req_ack.
  - req_data is ignored after capture; a new result may be driven immediately after req_ack.
  - req_valid changes during SEND have no effect until the return to IDLE.
- Counter width is $clog2(NUM_NEURON+1). With NUM_NEURON=1, word 0 has out_last=1.
- Reset values (reset low, applied asynchronously): state=IDLE, pointer=0, counter=0, hold register=0, req_ack=0, out_valid=0, out_data=0, out_src=0, out_last=0, busy=0. A transfer in progress is discarded and not re-acknowledged.

## Timing
- Grant latency: req_valid sampled high in IDLE at edge N gives out_valid, word 0 and req_ack at edge N (visible in cycle N+1).
- Word k+1 appears the cycle after word k is accepted. Full throughput is one word per cycle with out_ready held high.
- One mandatory IDLE bubble (out_valid=0) between consecutive transfers.
- A transfer takes NUM_NEURON accepted beats plus stall cycles.
- Simultaneous requests resolve in the IDLE cycle by pointer order only. Losers wait; their req_ack is not asserted.
- Reset release takes effect at the first clk edge with reset high. A req_valid pending at that edge is granted from pointer 0.

## Configuration
- SCHED_FIXED_PRIO_EN defined: the lowest-index set req_valid bit always wins. The pointer stays 0 and is never updated.
- SCHED_FIXED_PRIO_EN undefined (default): round-robin as described under Operation.

## Test plan
- Reset: drive reset low mid-sim with random inputs → all outputs 0 asynchronously, before the next clk edge.
- Single transfer (NUM_REQ=4, NUM_NEURON=3, `dataWidth=16): req 1 with words 0x0011/0x0022/0x0033, out_ready=1.
  - Expect out_data 0x0011, 0x0022, 0x0033 on 3 consecutive cycles.
  - Expect out_src=1 throughout, out_last only on 0x0033, and one req_ack[1] pulse coinciding with 0x0011.
- Backpressure: same transfer, out_ready=0 for 2 cycles while 0x0022 is presented → out_data stays 0x0022 with out_valid=1, no word skipped or duplicated.
- Round-robin: req_valid 0 and 2 held high continuously.
  - Expect grants 0, 2, 0, 2, with a 1-cycle out_valid=0 gap between transfers.
  - With SCHED_FIXED_PRIO_EN defined, expect grants 0, 0, 0.
- Reset mid-transfer: assert reset during word 2, keep req 3 pending → after release, req 3 is granted from pointer 0 and its full 3 words are sent from word 0.
- NUM_NEURON=1: single request → one word with out_last=1, then IDLE.

Source files
------------

// File: rtl/out_scheduler.sv
// rtl/out_scheduler.sv - round-robin scheduler serialising parallel layer results onto one word stream
// Optional build macro: SCHED_FIXED_PRIO_EN (lowest-index requester always wins, pointer frozen at 0).
`timescale 1ns/1ps
`ifndef dataWidth
`define dataWidth 16
`endif

module out_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int NUM_NEURON = 30
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_REQ-1:0]                        req_valid,
    input  logic [NUM_REQ*NUM_NEURON*`dataWidth-1:0]  req_data,
    output logic [NUM_REQ-1:0]                        req_ack,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [`dataWidth-1:0]                     out_data,
    output logic [$clog2(NUM_REQ)-1:0]                out_src,
    output logic                                      out_last,
    output logic                                      busy
);

    localparam int DW      = `dataWidth;
    localparam int SLICE_W = NUM_NEURON * DW;
    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int CNT_W   = $clog2(NUM_NEURON + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     r_src;
    logic [CNT_W-1:0]     r_cnt;
    logic [SLICE_W-1:0]   r_hold;
    logic [NUM_REQ-1:0]   r_ack;

    logic                 w_found;
    logic [PTR_W-1:0]     w_grant;
    logic [PTR_W:0]       w_sum;
    logic                 w_last;
    logic                 w_grant_fire;
    logic                 w_beat;

    // Search starts at the pointer and wraps; the extra sum bit keeps the wrap exact
    // for non-power-of-two requester counts.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W+1)'(i);
            if (w_sum >= (PTR_W+1)'(NUM_REQ))
                w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
            if (!w_found && req_valid[w_sum[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_sum[PTR_W-1:0];
            end
        end
    end

    assign w_last       = (r_cnt == CNT_W'(NUM_NEURON - 1));
    assign w_grant_fire = (r_state == S_IDLE) && w_found;
    assign w_beat       = (r_state == S_SEND) && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_next = S_SEND;
            S_SEND:  if (out_ready && w_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr  <= '0;
            r_src  <= '0;
            r_cnt  <= '0;
            r_hold <= '0;
            r_ack  <= '0;
        end else begin
            r_ack <= '0;
            if (w_grant_fire) begin
                r_hold         <= req_data[w_grant*SLICE_W +: SLICE_W];
                r_src          <= w_grant;
                r_cnt          <= '0;
                r_ack[w_grant] <= 1'b1;
            end else if (w_beat) begin
                if (w_last) begin
`ifndef SCHED_FIXED_PRIO_EN
                    r_ptr <= (r_src == PTR_W'(NUM_REQ - 1)) ? '0 : r_src + 1'b1;
`endif
                end else begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_hold <= r_hold >> DW;
                end
            end
        end
    end

    // The low word of the hold register is always the word on the wire.
    assign out_data  = r_hold[DW-1:0];
    assign out_valid = (r_state == S_SEND);
    assign busy      = (r_state == S_SEND);
    assign out_last  = w_last && (r_state == S_SEND);
    assign out_src   = r_src;
    assign req_ack   = r_ack;

endmodule

// File: tb/tb_out_scheduler.sv
// tb/tb_out_scheduler.sv - directed self-checking bench for out_scheduler
`timescale 1ns/1ps
`ifndef dataWidth
`define dataWidth 16
`endif

module tb_out_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;

    logic [3:0]   req_valid;
    logic [191:0] req_data;
    logic [3:0]   req_ack;
    logic         out_valid, out_ready, out_last, busy;
    logic [15:0]  out_data;
    logic [1:0]   out_src;

    logic [3:0]   req_valid1;
    logic [63:0]  req_data1;
    logic [3:0]   req_ack1;
    logic         out_valid1, out_ready1, out_last1, busy1;
    logic [15:0]  out_data1;
    logic [1:0]   out_src1;

    logic [24:0]  obs, obs1;
    int           pass_cnt = 0;
    int           total_cnt = 0;

    always #5 clk = ~clk;

    out_scheduler #(.NUM_REQ(4), .NUM_NEURON(3)) dut (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ack(req_ack),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_src(out_src), .out_last(out_last), .busy(busy)
    );

    out_scheduler #(.NUM_REQ(4), .NUM_NEURON(1)) dut1 (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid1), .req_data(req_data1), .req_ack(req_ack1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_src(out_src1), .out_last(out_last1), .busy(busy1)
    );

    assign obs  = {busy,  out_valid,  out_last,  out_src,  req_ack,  out_data};
    assign obs1 = {busy1, out_valid1, out_last1, out_src1, req_ack1, out_data1};

    task automatic set_req(input int r, input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2);
        req_data[r*48 +: 16]      = w0;
        req_data[r*48 + 16 +: 16] = w1;
        req_data[r*48 + 32 +: 16] = w2;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        out_ready  = 1'b1;
        req_valid1 = '0;
        req_data1  = '0;
        out_ready1 = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (obs !== 25'h0) $display("FAIL reset dut: got %h expected %h", obs, 25'h0);
        else pass_cnt++;
        total_cnt++;
        if (obs1 !== 25'h0) $display("FAIL reset dut1: got %h expected %h", obs1, 25'h0);
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        int          g [4];
        logic [24:0] exp;
        logic [15:0] w;
`ifdef SCHED_FIXED_PRIO_EN
        g = '{0, 0, 0, 0};
`else
        g = '{0, 2, 0, 2};
`endif
        set_req(0, 16'hA001, 16'hA002, 16'hA003);
        set_req(2, 16'hC001, 16'hC002, 16'hC003);
        req_valid = 4'b0101;
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                w   = ((g[t] == 0) ? 16'hA000 : 16'hC000) + 16'(k + 1);
                exp = {1'b1, 1'b1, (k == 2), 2'(g[t]), (k == 0) ? 4'(1 << g[t]) : 4'b0, w};
                total_cnt++;
                if (obs !== exp)
                    $display("FAIL rr t%0d k%0d: got %h expected %h", t, k, obs, exp);
                else pass_cnt++;
            end
            @(negedge clk);
            total_cnt++;
            if ({busy, out_valid, out_last, req_ack} !== 7'h0)
                $display("FAIL rr_bubble t%0d: got %h expected %h", t,
                         {busy, out_valid, out_last, req_ack}, 7'h0);
            else pass_cnt++;
            if (t == 3) req_valid = '0;
        end
    endtask

    task automatic test_single();
        logic [15:0] wv [3];
        logic [24:0] exp;
        wv = '{16'h0011, 16'h0022, 16'h0033};
        set_req(1, wv[0], wv[1], wv[2]);
        req_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exp = {1'b1, 1'b1, (k == 2), 2'd1, (k == 0) ? 4'b0010 : 4'b0, wv[k]};
            total_cnt++;
            if (obs !== exp) $display("FAIL single k%0d: got %h expected %h", k, obs, exp);
            else pass_cnt++;
            if (k == 0) begin
                req_valid = '0;
                set_req(1, 16'hDEAD, 16'hDEAD, 16'hDEAD);
            end
        end
        @(negedge clk);
        total_cnt++;
        if ({busy, out_valid, out_last, req_ack} !== 7'h0)
            $display("FAIL single_idle: got %h expected %h", {busy, out_valid, out_last, req_ack}, 7'h0);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [15:0] wv [5];
        logic [24:0] exp;
        wv = '{16'h0011, 16'h0022, 16'h0022, 16'h0022, 16'h0033};
        set_req(1, 16'h0011, 16'h0022, 16'h0033);
        req_valid = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            exp = {1'b1, 1'b1, (c == 4), 2'd1, (c == 0) ? 4'b0010 : 4'b0, wv[c]};
            total_cnt++;
            if (obs !== exp) $display("FAIL backpressure c%0d: got %h expected %h", c, obs, exp);
            else pass_cnt++;
            if (c == 0) req_valid = '0;
            out_ready = (c == 1 || c == 2) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        total_cnt++;
        if ({busy, out_valid, out_last, req_ack} !== 7'h0)
            $display("FAIL bp_idle: got %h expected %h", {busy, out_valid, out_last, req_ack}, 7'h0);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_transfer();
        logic [15:0] wv [3];
        logic [24:0] exp;
        wv = '{16'h3301, 16'h3302, 16'h3303};
        for (int r = 0; r < 3; r++) set_req(r, 16'($urandom), 16'($urandom), 16'($urandom));
        set_req(3, wv[0], wv[1], wv[2]);
        req_valid = 4'b1000;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            exp = {1'b1, 1'b1, 1'b0, 2'd3, (k == 0) ? 4'b1000 : 4'b0, wv[k]};
            total_cnt++;
            if (obs !== exp) $display("FAIL pre_reset k%0d: got %h expected %h", k, obs, exp);
            else pass_cnt++;
        end
        #2;
        rst_n      = 1'b0;
        req_valid  = 4'($urandom) | 4'b1000;
        out_ready  = 1'($urandom);
        req_valid1 = 4'($urandom);
        req_data1  = {$urandom, $urandom};
        out_ready1 = 1'($urandom);
        #1;
        total_cnt++;
        if (obs !== 25'h0) $display("FAIL async_reset dut: got %h expected %h", obs, 25'h0);
        else pass_cnt++;
        total_cnt++;
        if (obs1 !== 25'h0) $display("FAIL async_reset dut1: got %h expected %h", obs1, 25'h0);
        else pass_cnt++;
        @(negedge clk);
        rst_n      = 1'b1;
        req_valid  = 4'b1000;
        out_ready  = 1'b1;
        req_valid1 = '0;
        out_ready1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exp = {1'b1, 1'b1, (k == 2), 2'd3, (k == 0) ? 4'b1000 : 4'b0, wv[k]};
            total_cnt++;
            if (obs !== exp) $display("FAIL post_reset k%0d: got %h expected %h", k, obs, exp);
            else pass_cnt++;
            if (k == 0) req_valid = '0;
        end
        @(negedge clk);
        total_cnt++;
        if ({busy, out_valid, out_last, req_ack} !== 7'h0)
            $display("FAIL post_reset_idle: got %h expected %h", {busy, out_valid, out_last, req_ack}, 7'h0);
        else pass_cnt++;
    endtask

    task automatic test_single_word();
        logic [24:0] exp;
        int          g2 [2];
`ifdef SCHED_FIXED_PRIO_EN
        g2 = '{0, 0};
`else
        g2 = '{3, 0};
`endif
        req_data1[32 +: 16] = 16'hBEEF;
        req_valid1 = 4'b0100;
        @(negedge clk);
        exp = {1'b1, 1'b1, 1'b1, 2'd2, 4'b0100, 16'hBEEF};
        total_cnt++;
        if (obs1 !== exp) $display("FAIL nn1_word: got %h expected %h", obs1, exp);
        else pass_cnt++;
        req_valid1 = '0;
        @(negedge clk);
        total_cnt++;
        if ({busy1, out_valid1, out_last1, req_ack1} !== 7'h0)
            $display("FAIL nn1_idle: got %h expected %h", {busy1, out_valid1, out_last1, req_ack1}, 7'h0);
        else pass_cnt++;
        req_data1[0 +: 16]  = 16'h0A0A;
        req_data1[48 +: 16] = 16'h3C3C;
        req_valid1 = 4'b1001;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            exp = {1'b1, 1'b1, 1'b1, 2'(g2[t]), 4'(1 << g2[t]),
                   (g2[t] == 3) ? 16'h3C3C : 16'h0A0A};
            total_cnt++;
            if (obs1 !== exp) $display("FAIL nn1_rr t%0d: got %h expected %h", t, obs1, exp);
            else pass_cnt++;
            @(negedge clk);
            if (t == 1) req_valid1 = '0;
        end
        total_cnt++;
        if (out_valid1 !== 1'b0) $display("FAIL nn1_rr_bubble: got %b expected %b", out_valid1, 1'b0);
        else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_reset_mid_transfer();
        test_single_word();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
